// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// New display values are handshaked in and only take effect at a frame boundary.
module seven_seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 100000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [4*NUM_DIGITS-1:0] Value,
    input  logic                    Value_Valid,
    output logic                    Value_Ready,
    input  logic [NUM_DIGITS-1:0]   Digit_En,
    input  logic                    Blank_Lead,
    input  logic [NUM_DIGITS-1:0]   Dp_In,
    output logic [3:0]              Bin,
    output logic [NUM_DIGITS-1:0]   Anode,
    output logic                    Dp,
    output logic                    Frame_Start
);

    localparam int unsigned CNT_W = $clog2(PRESCALE);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      CntLast  = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]      IdxLast  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AnodeOff = {NUM_DIGITS{ACTIVE_LOW}};

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      display_q, display_d;
    logic [VAL_W-1:0]      pending_q, pending_d;
    logic                  pend_full_q, pend_full_d;
    logic                  ready_q;
    logic                  frame_start_q;
    logic [3:0]            bin_q, bin_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  dp_q, dp_d;

    logic                  tick;
    logic                  frame_wrap;
    logic                  accept;
    logic                  lit;
    logic                  dp_req;
    logic [NUM_DIGITS-1:0] sel;

    assign tick       = (cnt_q == CntLast);
    assign frame_wrap = tick && (idx_q == IdxLast);
    assign accept     = Value_Valid && ready_q;

    // Scan position: prescaler and digit index.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        end
    end

    // Accept and commit never coincide: accept needs an empty slot, commit a full one.
    always_comb begin
        display_d   = display_q;
        pending_d   = pending_q;
        pend_full_d = pend_full_q;
        if (frame_wrap && pend_full_q) begin
            display_d   = pending_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pending_d   = Value;
            pend_full_d = 1'b1;
        end
    end

    // Digit select, leading-zero blanking and decimal point for the current slot.
    always_comb begin
        bin_d  = '0;
        sel    = '0;
        lit    = 1'b0;
        dp_req = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                bin_d  = display_q[4*i +: 4];
                sel[i] = 1'b1;
                lit    = Digit_En[i] &&
                         !(Blank_Lead && (i != 0) && ((display_q >> (4 * i)) == '0));
                dp_req = Dp_In[i];
            end
        end
        anode_d = lit ? (sel ^ AnodeOff) : AnodeOff;
        dp_d    = (lit && dp_req) ^ ACTIVE_LOW;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            display_q     <= '0;
            pending_q     <= '0;
            pend_full_q   <= 1'b0;
            ready_q       <= 1'b0;
            frame_start_q <= 1'b0;
            bin_q         <= '0;
            anode_q       <= AnodeOff;
            dp_q          <= ACTIVE_LOW;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            display_q     <= display_d;
            pending_q     <= pending_d;
            pend_full_q   <= pend_full_d;
            ready_q       <= !pend_full_d;
            frame_start_q <= frame_wrap;
            bin_q         <= bin_d;
            anode_q       <= anode_d;
            dp_q          <= dp_d;
        end
    end

    assign Value_Ready = ready_q;
    assign Frame_Start = frame_start_q;
    assign Bin         = bin_q;
    assign Anode       = anode_q;
    assign Dp          = dp_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed scenarios plus random traffic, checked each cycle
// against a time-based reference model of scan position, handshake queue and blanking.
module tb_seven_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int PS    = 4;
    localparam int FRAME = ND * PS;

    logic        clk = 1'b0;
    logic        Reset;
    logic [15:0] Value;
    logic        Value_Valid;
    logic        Value_Ready;
    logic [3:0]  Digit_En;
    logic        Blank_Lead;
    logic [3:0]  Dp_In;
    logic [3:0]  Bin;
    logic [3:0]  Anode;
    logic        Dp;
    logic        Frame_Start;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(ND),
        .PRESCALE  (PS),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .Clk        (clk),
        .Reset      (Reset),
        .Value      (Value),
        .Value_Valid(Value_Valid),
        .Value_Ready(Value_Ready),
        .Digit_En   (Digit_En),
        .Blank_Lead (Blank_Lead),
        .Dp_In      (Dp_In),
        .Bin        (Bin),
        .Anode      (Anode),
        .Dp         (Dp),
        .Frame_Start(Frame_Start)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: t = clock edges since reset released; display/pending as a queue.
    int          t = 0;
    logic [15:0] disp = '0;
    logic [15:0] pend_q[$];
    logic [3:0]  exp_anode, exp_bin;
    logic        exp_dp, exp_fs, exp_ready;
    bit          model_on = 1'b0;
    bit          last_accept = 1'b0;

    logic [3:0]  cur_en = 4'hF;
    logic        cur_bl = 1'b0;
    logic [3:0]  cur_dp = 4'h0;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", tag, obs, exp, t, $time);
        end
    endtask

    // Check outputs from the previous edge, drive the next inputs, advance the model by one edge.
    task automatic step(input logic rst, input logic vld, input logic [15:0] val,
                        input logic [3:0] en, input logic bl, input logic [3:0] dp);
        int   d;
        logic dark;
        if (model_on) begin
            check_eq("anode", 16'(Anode), 16'(exp_anode));
            check_eq("bin", 16'(Bin), 16'(exp_bin));
            check_eq("dp", 16'(Dp), 16'(exp_dp));
            check_eq("frame_start", 16'(Frame_Start), 16'(exp_fs));
            check_eq("ready", 16'(Value_Ready), 16'(exp_ready));
        end
        Reset       = rst;
        Value_Valid = vld;
        Value       = val;
        Digit_En    = en;
        Blank_Lead  = bl;
        Dp_In       = dp;
        last_accept = 1'b0;
        if (rst) begin
            t         = 0;
            disp      = '0;
            pend_q.delete();
            exp_anode = 4'hF;
            exp_bin   = 4'h0;
            exp_dp    = 1'b1;
            exp_fs    = 1'b0;
            exp_ready = 1'b0;
            model_on  = 1'b1;
        end else begin
            d         = (t / PS) % ND;
            dark      = !en[d] || (bl && d != 0 && 32'(disp) < (32'd1 << (4 * d)));
            exp_bin   = disp[4*d +: 4];
            exp_anode = dark ? 4'hF : ~(4'b0001 << d);
            exp_dp    = dark ? 1'b1 : ~dp[d];
            last_accept = vld && exp_ready;
            exp_fs    = (t % FRAME) == FRAME - 1;
            if (exp_fs && pend_q.size() > 0) disp = pend_q.pop_front();
            if (last_accept) pend_q.push_back(val);
            exp_ready = (pend_q.size() == 0);
            t++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, cur_en, cur_bl, cur_dp);
    endtask

    // Offer a value with Valid held until the model says it was taken (bounded).
    task automatic send(input logic [15:0] val);
        int k;
        k = 0;
        do begin
            step(1'b0, 1'b1, val, cur_en, cur_bl, cur_dp);
            k++;
        end while (!last_accept && k < 3 * FRAME);
        if (!last_accept) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: value %h not accepted within %0d cycles", val, k);
        end
    endtask

    task automatic idle_until_slot(input int slot_pos);
        for (int i = 0; i < FRAME && (t % FRAME) != slot_pos; i++) idle(1);
    endtask

    initial begin
        Reset = 1'b1; Value = '0; Value_Valid = 1'b0;
        Digit_En = 4'hF; Blank_Lead = 1'b0; Dp_In = 4'h0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, cur_en, cur_bl, cur_dp);

        // Free-running scan of zero.
        idle(40);

        // Mid-frame update, then back-to-back values.
        idle_until_slot(6);
        send(16'h1A2F);
        idle(2 * FRAME);
        send(16'h1111);
        send(16'h2222);
        idle(3 * FRAME);

        // Leading-zero blanking.
        cur_bl = 1'b1;
        send(16'h0050);
        idle(2 * FRAME);
        send(16'h0000);
        idle(2 * FRAME);
        cur_bl = 1'b0;

        // Disabled digits and decimal point on a disabled digit.
        send(16'h4321);
        cur_en = 4'b0101;
        cur_dp = 4'b0010;
        idle(2 * FRAME);
        cur_dp = 4'b0101;
        idle(FRAME);
        cur_en = 4'hF;
        cur_dp = 4'h0;

        // Reset during digit 2 with a value pending.
        idle(FRAME);
        idle_until_slot(2);
        send(16'hBEEF);
        idle_until_slot(9);
        step(1'b1, 1'b0, 16'h0, cur_en, cur_bl, cur_dp);
        step(1'b1, 1'b0, 16'h0, cur_en, cur_bl, cur_dp);
        idle(2 * FRAME);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            logic        rst, vld, bl;
            logic [15:0] val;
            logic [3:0]  en, dp;
            rst = ($urandom_range(0, 199) == 0);
            vld = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       val = 16'($urandom);
                1:       val = 16'($urandom_range(0, 15)) << (4 * $urandom_range(0, 3));
                2:       val = 16'h0000;
                default: val = 16'($urandom_range(0, 255));
            endcase
            en = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            bl = 1'($urandom_range(0, 1));
            dp = 4'($urandom);
            step(rst, vld, val, en, bl, dp);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
